ps2_key_encoder: RTL and testbench
==================================

Name: ps2_key_encoder

Overview:
- Builds the 65-bit `ps2_key` event word from a raw PS/2 set-2 scancode byte stream, one event per completed key sequence.
- Consumers use the existing decode convention, so they need no changes:
  - bit 64 toggles once per event.
  - [7:0] holds the key code.
  - [15:8] is F0 for a release, or E0 for an extended press.
  - [23:16] is E0 for an extended release.
  - A non-zero [63:24] marks PRNSCR/PAUSE.
- Sits between a PS/2 byte receiver (or a test byte source) and the game input decode logic, all on `clk_sys`.

Parameters:
- TIMEOUT_CYCLES, 2000000: idle cycles after which a partially received sequence is discarded.
- DROP_CTRL, 1: when 1, controller response bytes FA/AA/EE/FE/00/FF received in IDLE are dropped.

Ports:
- clk_sys  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- byte_valid  in  1  one-cycle qualifier for byte_data; every asserted byte is accepted, there is no backpressure
- byte_data  in  8  received scancode byte
- ps2_key  out  65  event word: [64] toggle, [63:0] last bytes of the sequence, newest byte in [7:0]
- key_strobe  out  1  one-cycle pulse, coincident with the ps2_key update
- busy  out  1  high while a sequence is partially accumulated (state != IDLE)

Behaviour:
- Reset (asynchronous, active-high; all regs): ps2_key=0, key_strobe=0, acc=0, cnt=0, timer=0, state=IDLE.
  - Reset mid-sequence discards the partial sequence.
  - The toggle bit returns to 0.
- Accumulator acc[63:0]: each accepted byte shifts in as acc <= {acc[55:0], byte_data}. After 8 bytes the oldest byte falls off.
- States: IDLE, PREFIX, PRNSCR, PAUSE.
- IDLE:
  - E0 or F0: shift into acc, go to PREFIX.
  - E1: shift, cnt=7, go to PAUSE.
  - Control byte with DROP_CTRL=1: ignored, no state change.
  - Any other byte: terminating byte, complete the event.
- PREFIX:
  - E0 or F0: shift, stay.
  - Fake-shift pair "E0 12" (PRNSCR make) or "E0 F0 7C" (PRNSCR break first half), checked on acc plus the incoming byte: shift, go to PRNSCR.
  - Any other byte: complete the event.
- PRNSCR: E0 and F0 shift and stay; any other byte completes the event with the full sequence.
  - Make: E0 12 E0 7C gives [31:0]=E012E07C.
  - Break: E0 F0 7C E0 F0 12 gives [47:0]=E0F07CE0F012.
- PAUSE: shift each byte and decrement cnt. On the byte where cnt==1, complete the event with [63:0]=E11477E1F014F077.
- Completing an event, at the clock edge that accepts the terminating byte:
  - ps2_key[63:0] <= {acc[55:0], byte}.
  - ps2_key[64] <= ~ps2_key[64].
  - key_strobe <= 1 for exactly one cycle.
  - acc <= 0, state <= IDLE.
  - Latency: the event is visible 1 cycle after the byte_valid cycle.
- ps2_key holds its value between events. With no events, bits [63:0] are never altered.
- Timeout: timer counts cycles in a non-IDLE state without byte_valid and clears on each accepted byte. When timer reaches TIMEOUT_CYCLES-1: acc=0, state=IDLE, no event, ps2_key unchanged.
- Back-to-back byte_valid on consecutive cycles is fully supported. A byte arriving in the cycle after a completion starts a new sequence from clean acc.
- A byte arriving in the same cycle the timeout fires is processed as the first byte from IDLE; the timeout clear takes priority over the shift.
- Timer width is $clog2(TIMEOUT_CYCLES). Timer saturation is not needed because it clears at the limit.

Decomposition:
- Package ps2_key_pkg:
  - state enum (IDLE, PREFIX, PRNSCR, PAUSE).
  - Byte constants: PS2_EXT=E0, PS2_REL=F0, PS2_PAUSE=E1, PRNSCR_A=12, PRNSCR_B=7C, PAUSE_LEN=8.
  - Control-byte list for the drop check.
- One natural sub-module: ps2_seq_timeout (loadable idle counter with expiry pulse).
- The FSM, accumulator and output register stay in the top module.

Test Plan:
- Plain press/release:
  - Bytes 75 → ps2_key[15:0]=0075, [64]=1, one-cycle key_strobe.
  - Then F0 75 → [15:0]=F075, [64]=0.
- Extended:
  - E0 74 → [15:0]=E074.
  - Then E0 F0 74 → [23:0]=E0F074, [63:24]=0, toggle flips each time.
- PRNSCR and PAUSE:
  - E0 12 E0 7C yields exactly one event with [31:0]=E012E07C.
  - The 8-byte pause sequence yields one event with [63:0]=E11477E1F014F077. busy is high throughout both.
- Timeout:
  - E0, then TIMEOUT_CYCLES idle cycles → busy drops, no strobe, ps2_key unchanged.
  - A following 29 → [15:0]=0029.
- Back-to-back and reset:
  - 14 on one cycle and 14 on the next → two strobes, toggle returns to its original value.
  - RESET asserted after E0 F0 → ps2_key=0, busy=0, and the next byte 6B gives [15:0]=006B.
- Control drop: AA, FA in IDLE with DROP_CTRL=1 → no strobe, state stays IDLE.

Source files
------------

// File: rtl/ps2_key_pkg.sv
// Shared types and byte constants for the PS/2 set-2 scancode-to-event encoder.
package ps2_key_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PREFIX = 2'd1,
      PRNSCR = 2'd2,
      PAUSE  = 2'd3
   } state_e;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_REL   = 8'hF0;
   localparam logic [7:0] PS2_PAUSE = 8'hE1;
   localparam logic [7:0] PRNSCR_A  = 8'h12;
   localparam logic [7:0] PRNSCR_B  = 8'h7C;
   localparam int         PAUSE_LEN = 8;

   // Keyboard controller responses (ACK, BAT ok, echo, resend, errors).
   localparam int         N_CTRL = 6;
   localparam logic [7:0] CTRL_BYTES [N_CTRL] = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

   function automatic logic is_ctrl_byte(input logic [7:0] b);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < N_CTRL; i++) begin
         if (b == CTRL_BYTES[i]) begin
            hit = 1'b1;
         end
      end
      return hit;
   endfunction

   function automatic logic is_prefix_byte(input logic [7:0] b);
      return (b == PS2_EXT) || (b == PS2_REL);
   endfunction

endpackage

// File: rtl/ps2_seq_timeout.sv
// Idle-cycle counter for a partially received sequence; pulses expired on the
// cycle the count reaches TIMEOUT_CYCLES-1 while run is high.
module ps2_seq_timeout #(
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic load,
   output logic expired
);

   localparam int            TW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] timer_q;
   logic [TW-1:0] timer_d;

   assign expired = run && (timer_q == LIMIT);

   // Clearing at the limit means the counter never needs to saturate.
   always_comb begin
      timer_d = timer_q;
      if (!run || load || expired) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + TW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

endmodule

// File: rtl/ps2_key_encoder.sv
// Assembles PS/2 set-2 scancode bytes into the 65-bit toggle-qualified ps2_key
// event word, one event per completed make/break/PRNSCR/PAUSE sequence.
module ps2_key_encoder
   import ps2_key_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int DROP_CTRL      = 1
) (
   input  logic        clk_sys,
   input  logic        RESET,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic [64:0] ps2_key,
   output logic        key_strobe,
   output logic        busy
);

   localparam int CNT_W = 4;

   state_e        state_q, state_d;
   // Only seven bytes of history ever reach the event word, so the eighth is not kept.
   logic [55:0]   acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [64:0]   key_q, key_d;
   logic          strobe_q, strobe_d;

   state_e        cur_state;
   logic [55:0]   cur_acc;
   logic [63:0]   shifted;
   logic          complete;
   logic          fake_shift;
   logic          expired;

   ps2_seq_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk_sys),
      .rst     (RESET),
      .run     (state_q != IDLE),
      .load    (byte_valid),
      .expired (expired)
   );

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      key_d     = key_q;
      strobe_d  = 1'b0;
      complete  = 1'b0;
      cur_state = state_q;
      cur_acc   = acc_q;

      // An expiring sequence is discarded first; a byte in the same cycle starts fresh.
      if (expired) begin
         cur_state = IDLE;
         cur_acc   = '0;
         state_d   = IDLE;
         acc_d     = '0;
         cnt_d     = '0;
      end

      shifted    = {cur_acc, byte_data};
      fake_shift = ((cur_acc[7:0] == PS2_EXT) && (byte_data == PRNSCR_A)) ||
                   ((cur_acc[15:0] == {PS2_EXT, PS2_REL}) && (byte_data == PRNSCR_B));

      if (byte_valid) begin
         case (cur_state)
            IDLE: begin
               if (is_prefix_byte(byte_data)) begin
                  acc_d   = shifted[55:0];
                  state_d = PREFIX;
               end else if (byte_data == PS2_PAUSE) begin
                  acc_d   = shifted[55:0];
                  cnt_d   = CNT_W'(PAUSE_LEN - 1);
                  state_d = PAUSE;
               end else if (!((DROP_CTRL != 0) && is_ctrl_byte(byte_data))) begin
                  complete = 1'b1;
               end
            end
            PREFIX: begin
               if (fake_shift) begin
                  acc_d   = shifted[55:0];
                  state_d = PRNSCR;
               end else if (is_prefix_byte(byte_data)) begin
                  acc_d = shifted[55:0];
               end else begin
                  complete = 1'b1;
               end
            end
            PRNSCR: begin
               if (is_prefix_byte(byte_data)) begin
                  acc_d = shifted[55:0];
               end else begin
                  complete = 1'b1;
               end
            end
            PAUSE: begin
               acc_d = shifted[55:0];
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  complete = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               acc_d   = '0;
            end
         endcase

         if (complete) begin
            key_d    = {~key_q[64], shifted};
            strobe_d = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = IDLE;
         end
      end
   end

   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         key_q    <= '0;
         strobe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         key_q    <= key_d;
         strobe_q <= strobe_d;
      end
   end

   assign ps2_key    = key_q;
   assign key_strobe = strobe_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed-vector bench for ps2_key_encoder with a short timeout.
module tb_ps2_key_encoder;

   localparam int TO = 16;

   logic        clk_sys    = 1'b0;
   logic        RESET      = 1'b1;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data  = 8'h00;
   logic [64:0] ps2_key;
   logic        key_strobe;
   logic        busy;

   int          n_vec    = 0;
   int          n_err    = 0;
   int          n_strobe = 0;
   logic        tog      = 1'b0;
   logic        tog0;
   logic [64:0] saved;
   int          s0;
   logic [7:0]  pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

   always #5 clk_sys = ~clk_sys;

   ps2_key_encoder #(
      .TIMEOUT_CYCLES (TO),
      .DROP_CTRL      (1)
   ) dut (
      .clk_sys    (clk_sys),
      .RESET      (RESET),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .ps2_key    (ps2_key),
      .key_strobe (key_strobe),
      .busy       (busy)
   );

   always @(negedge clk_sys) begin
      if (key_strobe) begin
         n_strobe <= n_strobe + 1;
      end
   end

   task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk_sys);
      byte_valid = 1'b1;
      byte_data  = b;
      @(negedge clk_sys);
      byte_valid = 1'b0;
      #1;
   endtask

   task automatic expect_event(input string tag, input logic [63:0] word);
      tog = ~tog;
      check(tag, ps2_key, {tog, word});
      $display("event %s: ps2_key=%h", tag, ps2_key);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: sim time %0t exceeded bound", $time);
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk_sys);
      #1;
      check("rst_key", ps2_key, 65'd0);
      check("rst_strobe", 65'(key_strobe), 65'd0);
      check("rst_busy", 65'(busy), 65'd0);
      @(negedge clk_sys);
      RESET = 1'b0;

      // plain press / release
      send(8'h75);
      check("press_strobe", 65'(key_strobe), 65'd1);
      expect_event("press_75", 64'h75);
      @(negedge clk_sys);
      #1;
      check("strobe_one_cycle", 65'(key_strobe), 65'd0);
      check("strobe_count_1", 65'(n_strobe), 65'd1);
      send(8'hF0);
      check("busy_after_F0", 65'(busy), 65'd1);
      send(8'h75);
      expect_event("release_75", 64'hF075);

      // extended press / release
      send(8'hE0);
      send(8'h74);
      expect_event("ext_press_74", 64'hE074);
      send(8'hE0);
      send(8'hF0);
      send(8'h74);
      expect_event("ext_release_74", 64'hE0F074);

      // PRNSCR make and break
      s0 = n_strobe;
      send(8'hE0);
      check("prn_busy_1", 65'(busy), 65'd1);
      send(8'h12);
      check("prn_busy_2", 65'(busy), 65'd1);
      send(8'hE0);
      check("prn_busy_3", 65'(busy), 65'd1);
      send(8'h7C);
      expect_event("prnscr_make", 64'hE012E07C);
      check("prn_make_strobes", 65'(n_strobe), 65'(s0 + 1));
      s0 = n_strobe;
      send(8'hE0);
      send(8'hF0);
      send(8'h7C);
      send(8'hE0);
      send(8'hF0);
      check("prn_brk_busy", 65'(busy), 65'd1);
      send(8'h12);
      expect_event("prnscr_break", 64'hE0F07CE0F012);
      check("prn_brk_strobes", 65'(n_strobe), 65'(s0 + 1));

      // PAUSE
      s0 = n_strobe;
      for (int i = 0; i < 7; i++) begin
         send(pause_seq[i]);
         check("pause_busy", 65'(busy), 65'd1);
      end
      send(pause_seq[7]);
      expect_event("pause", 64'hE11477E1F014F077);
      check("pause_strobes", 65'(n_strobe), 65'(s0 + 1));

      // timeout discards a lone prefix
      saved = ps2_key;
      s0    = n_strobe;
      send(8'hE0);
      repeat (TO - 1) @(negedge clk_sys);
      #1;
      check("to_busy_before", 65'(busy), 65'd1);
      @(negedge clk_sys);
      #1;
      check("to_busy_after", 65'(busy), 65'd0);
      check("to_key_kept", ps2_key, saved);
      check("to_no_strobe", 65'(n_strobe), 65'(s0));
      send(8'h29);
      expect_event("after_timeout_29", 64'h29);

      // byte one cycle before expiry continues the sequence
      send(8'hE0);
      repeat (TO - 3) @(negedge clk_sys);
      send(8'h74);
      expect_event("late_byte_kept", 64'hE074);

      // byte on the expiry cycle starts from a clean IDLE
      send(8'hE0);
      repeat (TO - 2) @(negedge clk_sys);
      send(8'h75);
      expect_event("byte_on_expiry", 64'h75);

      // back-to-back bytes
      tog0 = ps2_key[64];
      s0   = n_strobe;
      @(negedge clk_sys);
      byte_valid = 1'b1;
      byte_data  = 8'h14;
      @(negedge clk_sys);
      byte_data  = 8'h14;
      @(negedge clk_sys);
      byte_valid = 1'b0;
      @(negedge clk_sys);
      #1;
      tog = ~tog;
      expect_event("b2b_14_14", 64'h14);
      check("b2b_toggle_back", 65'(ps2_key[64]), 65'(tog0));
      check("b2b_strobes", 65'(n_strobe), 65'(s0 + 2));
      @(negedge clk_sys);
      byte_valid = 1'b1;
      byte_data  = 8'h1A;
      @(negedge clk_sys);
      byte_data  = 8'hE0;
      @(negedge clk_sys);
      byte_data  = 8'h5A;
      @(negedge clk_sys);
      byte_valid = 1'b0;
      #1;
      tog = ~tog;
      expect_event("b2b_clean_acc", 64'hE05A);

      // asynchronous reset mid-sequence
      send(8'hE0);
      send(8'hF0);
      check("pre_rst_busy", 65'(busy), 65'd1);
      @(negedge clk_sys);
      RESET = 1'b1;
      #1;
      check("async_rst_key", ps2_key, 65'd0);
      check("async_rst_busy", 65'(busy), 65'd0);
      @(negedge clk_sys);
      RESET = 1'b0;
      tog   = 1'b0;
      send(8'h6B);
      expect_event("after_reset_6B", 64'h6B);

      // controller bytes dropped in IDLE, but not inside a sequence
      saved = ps2_key;
      s0    = n_strobe;
      send(8'hAA);
      check("drop_AA_busy", 65'(busy), 65'd0);
      send(8'hFA);
      check("drop_FA_busy", 65'(busy), 65'd0);
      send(8'h00);
      check("drop_no_strobe", 65'(n_strobe), 65'(s0));
      check("drop_key_kept", ps2_key, saved);
      send(8'h1C);
      expect_event("after_drop_1C", 64'h1C);
      send(8'hE0);
      send(8'hFA);
      expect_event("prefix_FA", 64'hE0FA);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
